// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the execute sequencer: ALU opcodes, RV32I decode
// constants and FSM state encodings. Imported by alu_decode and alu_sequencer.
package alu_sequencer_pkg;

    // ALU operation select. Only these three encodings are ever driven.
    typedef enum logic [2:0] {
        ALU_OP_ADD = 3'b000,
        ALU_OP_SUB = 3'b100,
        ALU_OP_AND = 3'b111
    } alu_op_e;

    // RV32I major opcodes
    localparam logic [6:0] RV_OPC_OP     = 7'b0110011;
    localparam logic [6:0] RV_OPC_OP_IMM = 7'b0010011;

    // funct3 values
    localparam logic [2:0] RV_F3_ADD_SUB = 3'b000;
    localparam logic [2:0] RV_F3_AND     = 3'b111;

    // funct7 values
    localparam logic [6:0] RV_F7_BASE = 7'b0000000;
    localparam logic [6:0] RV_F7_ALT  = 7'b0100000;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } seq_state_e;

endpackage

// File: rtl/alu_sequencer_if.sv
// ALU operand/result bus. The sequencer is the master (drives opcode and
// operands); the ALU is the slave (returns a combinational result).
interface alu_sequencer_if #(
    parameter int XLEN = 32
);

    logic [2:0]      alu_opcode;
    logic [XLEN-1:0] alu_left;
    logic [XLEN-1:0] alu_right;
    logic [XLEN-1:0] alu_result;

    modport master (
        output alu_opcode,
        output alu_left,
        output alu_right,
        input  alu_result
    );

    modport slave (
        input  alu_opcode,
        input  alu_left,
        input  alu_right,
        output alu_result
    );

endinterface

// File: rtl/alu_decode.sv
// Combinational RV32I decoder for the execute sequencer.
// Recognises R-type ADD/SUB/AND; with ALU_SEQ_IMM_EN defined it also
// recognises I-type ADDI/ANDI and produces a sign-extended immediate.
module alu_decode
    import alu_sequencer_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output alu_op_e         alu_op,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
`ifdef ALU_SEQ_IMM_EN
    output logic            use_imm,
    output logic [XLEN-1:0] imm,
`endif
    output logic            legal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign rd     = instr[11:7];

    // Classify the instruction; anything not matched stays illegal.
    always_comb begin
        alu_op = ALU_OP_ADD;
        legal  = 1'b0;
`ifdef ALU_SEQ_IMM_EN
        use_imm = 1'b0;
        imm     = {{(XLEN-12){instr[31]}}, instr[31:20]};
`endif
        if (opcode == RV_OPC_OP) begin
            if (funct3 == RV_F3_ADD_SUB && funct7 == RV_F7_BASE) begin
                alu_op = ALU_OP_ADD;
                legal  = 1'b1;
            end else if (funct3 == RV_F3_ADD_SUB && funct7 == RV_F7_ALT) begin
                alu_op = ALU_OP_SUB;
                legal  = 1'b1;
            end else if (funct3 == RV_F3_AND && funct7 == RV_F7_BASE) begin
                alu_op = ALU_OP_AND;
                legal  = 1'b1;
            end
        end
`ifdef ALU_SEQ_IMM_EN
        else if (opcode == RV_OPC_OP_IMM) begin
            use_imm = 1'b1;
            if (funct3 == RV_F3_ADD_SUB) begin
                alu_op = ALU_OP_ADD;
                legal  = 1'b1;
            end else if (funct3 == RV_F3_AND) begin
                alu_op = ALU_OP_AND;
                legal  = 1'b1;
            end
        end
`endif
    end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle execute sequencer: accepts one RV32I instruction from fetch,
// reads operands from the register file, drives the ALU and writes back.
// Sequence is IDLE -> READ -> EXEC -> WB -> IDLE, one instruction per 4 cycles.
// Optional feature: define ALU_SEQ_IMM_EN to add ADDI/ANDI support.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                instr_valid,
    input  logic [31:0]         instr,
    output logic                instr_ready,

    output logic [REG_AW-1:0]   rs1_addr,
    output logic [REG_AW-1:0]   rs2_addr,
    input  logic [XLEN-1:0]     rs1_data,
    input  logic [XLEN-1:0]     rs2_data,

    alu_sequencer_if.master     alu_bus,

    output logic                wb_en,
    output logic [REG_AW-1:0]   wb_addr,
    output logic [XLEN-1:0]     wb_data,
    output logic                illegal,
    output logic                busy
);

    seq_state_e        state;
    logic              started_q;
    alu_op_e           op_q;
    logic [REG_AW-1:0] rd_q;
    logic [XLEN-1:0]   result_q;

    alu_op_e           dec_op;
    logic [4:0]        dec_rs1;
    logic [4:0]        dec_rs2;
    logic [4:0]        dec_rd;
    logic              dec_legal;

`ifdef ALU_SEQ_IMM_EN
    logic              dec_use_imm;
    logic [XLEN-1:0]   dec_imm;
    logic              use_imm_q;
    logic [XLEN-1:0]   imm_q;
`endif

    alu_decode #(
        .XLEN (XLEN)
    ) u_decode (
        .instr   (instr),
        .alu_op  (dec_op),
        .rs1     (dec_rs1),
        .rs2     (dec_rs2),
        .rd      (dec_rd),
`ifdef ALU_SEQ_IMM_EN
        .use_imm (dec_use_imm),
        .imm     (dec_imm),
`endif
        .legal   (dec_legal)
    );

    // started_q keeps instr_ready low for the first cycle after reset so
    // that every output reads zero while the reset is being observed.
    assign instr_ready = (state == ST_IDLE) && started_q;
    assign busy        = (state != ST_IDLE);

    // Sequencer FSM with registered operand, result and writeback outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state              <= ST_IDLE;
            started_q          <= 1'b0;
            op_q               <= ALU_OP_ADD;
            rd_q               <= '0;
            result_q           <= '0;
            rs1_addr           <= '0;
            rs2_addr           <= '0;
            alu_bus.alu_opcode <= 3'b000;
            alu_bus.alu_left   <= '0;
            alu_bus.alu_right  <= '0;
            wb_en              <= 1'b0;
            wb_addr            <= '0;
            wb_data            <= '0;
            illegal            <= 1'b0;
`ifdef ALU_SEQ_IMM_EN
            use_imm_q          <= 1'b0;
            imm_q              <= '0;
`endif
        end else begin
            started_q <= 1'b1;
            wb_en     <= 1'b0;
            illegal   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (instr_valid && instr_ready) begin
                        rs1_addr <= dec_rs1;
                        rs2_addr <= dec_rs2;
                        rd_q     <= dec_rd;
                        op_q     <= dec_op;
`ifdef ALU_SEQ_IMM_EN
                        use_imm_q <= dec_use_imm;
                        imm_q     <= dec_imm;
`endif
                        if (dec_legal) begin
                            state <= ST_READ;
                        end else begin
                            illegal <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    alu_bus.alu_opcode <= op_q;
                    alu_bus.alu_left   <= rs1_data;
`ifdef ALU_SEQ_IMM_EN
                    alu_bus.alu_right  <= use_imm_q ? imm_q : rs2_data;
`else
                    alu_bus.alu_right  <= rs2_data;
`endif
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    result_q <= alu_bus.alu_result;
                    state    <= ST_WB;
                end
                ST_WB: begin
                    wb_en   <= (rd_q != '0);
                    wb_addr <= rd_q;
                    wb_data <= result_q;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed testbench for alu_sequencer with a combinational register file
// and ALU model. ADDI/ANDI vectors run only when ALU_SEQ_IMM_EN is defined.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        illegal;
    logic        busy;

    logic [31:0] regs [32];

    int vectors     = 0;
    int miscompares = 0;

    alu_sequencer_if #(.XLEN(32)) alu_bus ();

    alu_sequencer u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .alu_bus     (alu_bus),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .illegal     (illegal),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Register file read ports; x0 always reads zero.
    assign rs1_data = (rs1_addr == 5'd0) ? 32'd0 : regs[rs1_addr];
    assign rs2_data = (rs2_addr == 5'd0) ? 32'd0 : regs[rs2_addr];

    // Reference ALU on the slave side of the bus.
    always_comb begin
        case (alu_bus.alu_opcode)
            3'b000:  alu_bus.alu_result = alu_bus.alu_left + alu_bus.alu_right;
            3'b100:  alu_bus.alu_result = alu_bus.alu_left - alu_bus.alu_right;
            3'b111:  alu_bus.alu_result = alu_bus.alu_left & alu_bus.alu_right;
            default: alu_bus.alu_result = 32'd0;
        endcase
    end

    function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                           input logic [4:0] rs1, input logic [2:0] f3,
                                           input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                           input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Waits (bounded) for instr_ready, then performs one handshake.
    // Returns #1 after the accepting edge.
    task automatic apply_stimulus(input string tag, input logic [31:0] word);
        for (int i = 0; i < 8 && instr_ready !== 1'b1; i++) begin
            @(posedge clk);
            #1;
        end
        check_output({tag, "_ready"}, 32'(instr_ready), 32'd1);
        instr_valid = 1'b1;
        instr       = word;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr       = 32'h0;
    endtask

    // Runs one legal instruction and checks the exact writeback cycle.
    task automatic run_alu(input string tag, input logic [31:0] word, input logic exp_en,
                           input logic [4:0] exp_addr, input logic [31:0] exp_data,
                           input logic [2:0] exp_op);
        apply_stimulus(tag, word);
        check_output({tag, "_busy"}, 32'(busy), 32'd1);
        check_output({tag, "_ill"}, 32'(illegal), 32'd0);
        for (int c = 1; c <= 2; c++) begin
            @(posedge clk);
            #1;
            check_output({tag, "_early_wb"}, 32'(wb_en), 32'd0);
        end
        @(posedge clk);
        #1;
        check_output({tag, "_wb_en"}, 32'(wb_en), 32'(exp_en));
        if (exp_en) begin
            check_output({tag, "_wb_addr"}, 32'(wb_addr), 32'(exp_addr));
            check_output({tag, "_wb_data"}, wb_data, exp_data);
        end
        check_output({tag, "_op"}, 32'(alu_bus.alu_opcode), 32'(exp_op));
        check_output({tag, "_busy_end"}, 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        check_output({tag, "_wb_pulse"}, 32'(wb_en), 32'd0);
    endtask

    // Presents an undecodable instruction and checks the one-cycle pulse.
    task automatic run_illegal(input string tag, input logic [31:0] word);
        apply_stimulus(tag, word);
        check_output({tag, "_ill"}, 32'(illegal), 32'd1);
        check_output({tag, "_busy"}, 32'(busy), 32'd0);
        check_output({tag, "_ready"}, 32'(instr_ready), 32'd1);
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk);
            #1;
            check_output({tag, "_ill_off"}, 32'(illegal), 32'd0);
            check_output({tag, "_wb_en"}, 32'(wb_en), 32'd0);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = 32'h0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_output("rst_ready", 32'(instr_ready), 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_wb_en", 32'(wb_en), 32'd0);
        check_output("rst_ill", 32'(illegal), 32'd0);
        check_output("rst_wb_data", wb_data, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_output("rst_ready_after", 32'(instr_ready), 32'd1);

        regs[1] = 32'd4;
        regs[2] = 32'd3;
        run_alu("add", r_type(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 1'b1, 5'd3, 32'd7, 3'b000);

        regs[1] = 32'd7;
        run_alu("sub", r_type(7'h20, 5'd2, 5'd1, 3'b000, 5'd4), 1'b1, 5'd4, 32'd4, 3'b100);

        regs[1] = 32'd0;
        regs[2] = 32'd1;
        run_alu("sub_wrap", r_type(7'h20, 5'd2, 5'd1, 3'b000, 5'd7), 1'b1, 5'd7, 32'hFFFF_FFFF, 3'b100);

        regs[10] = 32'hFFFF_FFFF;
        run_alu("add_wrap", r_type(7'h00, 5'd2, 5'd10, 3'b000, 5'd8), 1'b1, 5'd8, 32'd0, 3'b000);

        regs[1] = 32'b1100;
        regs[2] = 32'b1010;
        run_alu("and", r_type(7'h00, 5'd2, 5'd1, 3'b111, 5'd5), 1'b1, 5'd5, 32'b1000, 3'b111);
        run_alu("and_x0", r_type(7'h00, 5'd2, 5'd1, 3'b111, 5'd0), 1'b0, 5'd0, 32'd0, 3'b111);

        run_illegal("ecall", 32'h0000_0073);
        run_illegal("mul", r_type(7'h01, 5'd2, 5'd1, 3'b000, 5'd3));
        run_illegal("and_f7", r_type(7'h20, 5'd2, 5'd1, 3'b111, 5'd3));

`ifdef ALU_SEQ_IMM_EN
        regs[1]  = 32'd5;
        regs[31] = 32'h1234_5678;
        run_alu("addi", i_type(12'hFFF, 5'd1, 3'b000, 5'd6), 1'b1, 5'd6, 32'd4, 3'b000);
        check_output("addi_right", alu_bus.alu_right, 32'hFFFF_FFFF);
        regs[1] = 32'd0;
        run_alu("andi", i_type(12'h7FF, 5'd1, 3'b111, 5'd6), 1'b1, 5'd6, 32'd0, 3'b111);
        check_output("andi_right", alu_bus.alu_right, 32'h0000_07FF);
        run_illegal("ori", i_type(12'h001, 5'd1, 3'b110, 5'd6));
`else
        run_illegal("addi", i_type(12'hFFF, 5'd1, 3'b000, 5'd6));
`endif

        // Reset asserted for one edge while the sequencer is in EXEC.
        regs[1] = 32'd4;
        regs[2] = 32'd3;
        apply_stimulus("rst_exec", r_type(7'h00, 5'd2, 5'd1, 3'b000, 5'd9));
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_output("rexec_ready", 32'(instr_ready), 32'd0);
        check_output("rexec_busy", 32'(busy), 32'd0);
        check_output("rexec_wb_en", 32'(wb_en), 32'd0);
        check_output("rexec_ill", 32'(illegal), 32'd0);
        check_output("rexec_op", 32'(alu_bus.alu_opcode), 32'd0);
        check_output("rexec_left", alu_bus.alu_left, 32'd0);
        check_output("rexec_right", alu_bus.alu_right, 32'd0);
        check_output("rexec_wb_addr", 32'(wb_addr), 32'd0);
        check_output("rexec_wb_data", wb_data, 32'd0);
        check_output("rexec_rs1", 32'(rs1_addr), 32'd0);
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk);
            #1;
            check_output("rexec_no_wb", 32'(wb_en), 32'd0);
        end
        run_alu("post_rst", r_type(7'h00, 5'd2, 5'd1, 3'b000, 5'd9), 1'b1, 5'd9, 32'd7, 3'b000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Hard stop in case a handshake loop never terminates.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

endmodule
